// File: rtl/req_gen_pkg.sv
// Shared types for the multi-channel request generator.
package req_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        MODE_FREE    = 1'b0,
        MODE_BOUNDED = 1'b1
    } mode_t;

endpackage : req_gen_pkg

// File: rtl/req_gen_rr_arbiter.sv
// Combinational round-robin picker: first eligible index strictly after ptr_i, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_CH = 4,
    localparam int unsigned CH_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] elig_i,
    input  logic [CH_W-1:0]   ptr_i,
    output logic              gnt_valid_c,
    output logic [CH_W-1:0]   gnt_idx_c
);

    logic [CH_W-1:0] idx;

    always_comb begin
        gnt_valid_c = 1'b0;
        gnt_idx_c   = '0;
        idx         = '0;
        // Offset NUM_CH lands back on ptr_i itself, so it is checked last.
        for (int unsigned off = 1; off <= NUM_CH; off++) begin
            idx = CH_W'((32'(ptr_i) + off) % NUM_CH);
            if (!gnt_valid_c && elig_i[idx]) begin
                gnt_valid_c = 1'b1;
                gnt_idx_c   = idx;
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/req_gen.sv
// Multi-channel keyed request generator: per-channel counters, round-robin
// arbitration over one req/ack handshake, free-running or bounded operation.
module req_gen
    import req_gen_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned KEY_W  = 4,
    localparam int unsigned CH_W  = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [KEY_W-1:0]  limit,
    input  logic [NUM_CH-1:0] ch_en,
    output logic              req,
    output logic [CH_W-1:0]   req_ch,
    output logic [KEY_W-1:0]  req_key,
    input  logic              ack,
    output logic              done
);

    state_t            state_q, state_d;
    mode_t             mode_q, mode_d;
    logic [KEY_W-1:0]  limit_q, limit_d;
    logic [KEY_W-1:0]  cnt_q [NUM_CH];
    logic [KEY_W-1:0]  cnt_d [NUM_CH];
    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic              req_q, req_d;
    logic [CH_W-1:0]   req_ch_q, req_ch_d;
    logic [KEY_W-1:0]  req_key_q, req_key_d;
    logic              done_q, done_d;

    logic              load_c;
    logic [NUM_CH-1:0] elig_c;
    logic              gnt_valid_c;
    logic [CH_W-1:0]   gnt_idx_c;

    // Counter/parameter update; load_c marks edges where a fresh grant is loaded.
    always_comb begin
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        limit_d = limit_q;
        load_c  = 1'b0;
        if (start) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cnt_d[i] = '0;
            end
            mode_d  = mode_t'(mode);
            limit_d = limit;
            load_c  = 1'b1;
        end else if (state_q == RUN) begin
            if (req_q && ack) begin
                cnt_d[req_ch_q] = cnt_q[req_ch_q] + KEY_W'(1);
                load_c          = 1'b1;
            end else if (!req_q) begin
                load_c = 1'b1;
            end
        end
    end

    // Eligibility is judged on post-update counters and the effective mode/limit.
    always_comb begin
        elig_c = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            elig_c[i] = ch_en[i] && !((mode_d == MODE_BOUNDED) && (cnt_d[i] == limit_d));
        end
    end

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .elig_i      (elig_c),
        .ptr_i       (ptr_q),
        .gnt_valid_c (gnt_valid_c),
        .gnt_idx_c   (gnt_idx_c)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        req_d     = req_q;
        req_ch_d  = req_ch_q;
        req_key_d = req_key_q;
        done_d    = done_q;
        if (load_c) begin
            if (gnt_valid_c) begin
                state_d   = RUN;
                req_d     = 1'b1;
                req_ch_d  = gnt_idx_c;
                req_key_d = cnt_d[gnt_idx_c];
                ptr_d     = gnt_idx_c;
                done_d    = 1'b0;
            end else begin
                req_d = 1'b0;
                if (mode_d == MODE_BOUNDED) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = RUN;
                    done_d  = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= MODE_FREE;
            limit_q   <= '0;
            ptr_q     <= CH_W'(NUM_CH - 1);
            req_q     <= 1'b0;
            req_ch_q  <= '0;
            req_key_q <= '0;
            done_q    <= 1'b0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            mode_q    <= mode_d;
            limit_q   <= limit_d;
            ptr_q     <= ptr_d;
            req_q     <= req_d;
            req_ch_q  <= req_ch_d;
            req_key_q <= req_key_d;
            done_q    <= done_d;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign req     = req_q;
    assign req_ch  = req_ch_q;
    assign req_key = req_key_q;
    assign done    = done_q;

endmodule : req_gen

// File: tb/tb_req_gen.sv
// Self-checking bench for req_gen: directed scenarios plus randomized traffic
// compared against a behavioural channel/counter model.
module tb_req_gen;

    localparam int NUM_CH = 4;
    localparam int KEY_W  = 4;
    localparam int CH_W   = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              mode;
    logic [KEY_W-1:0]  limit;
    logic [NUM_CH-1:0] ch_en;
    logic              ack;
    logic              req;
    logic [CH_W-1:0]   req_ch;
    logic [KEY_W-1:0]  req_key;
    logic              done;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int m_cnt [NUM_CH];
    int m_ptr;
    bit m_bounded;
    int m_limit;
    bit m_active;
    bit m_req;
    bit m_done;
    int m_ch;
    int m_key;

    always #5 clk = ~clk;

    req_gen #(
        .NUM_CH (NUM_CH),
        .KEY_W  (KEY_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .mode    (mode),
        .limit   (limit),
        .ch_en   (ch_en),
        .req     (req),
        .req_ch  (req_ch),
        .req_key (req_key),
        .ack     (ack),
        .done    (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;
        m_ptr     = NUM_CH - 1;
        m_bounded = 1'b0;
        m_limit   = 0;
        m_active  = 1'b0;
        m_req     = 1'b0;
        m_done    = 1'b0;
        m_ch      = 0;
        m_key     = 0;
    endtask

    // One clock of expected behaviour, from the inputs present before the edge.
    task automatic model_step();
        bit pick;
        bit found;
        int c;
        pick  = 1'b0;
        found = 1'b0;
        c     = 0;
        if (start) begin
            for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;
            m_bounded = mode;
            m_limit   = int'(limit);
            pick      = 1'b1;
        end else if (m_active) begin
            if (m_req && ack) begin
                m_cnt[m_ch] = (m_cnt[m_ch] + 1) % (1 << KEY_W);
                pick        = 1'b1;
            end else if (!m_req) begin
                pick = 1'b1;
            end
        end
        if (pick) begin
            for (int k = 1; k <= NUM_CH; k++) begin
                int cand;
                cand = (m_ptr + k) % NUM_CH;
                if (!found && ch_en[cand] && !(m_bounded && m_cnt[cand] == m_limit)) begin
                    found = 1'b1;
                    c     = cand;
                end
            end
            if (found) begin
                m_req    = 1'b1;
                m_ch     = c;
                m_key    = m_cnt[c];
                m_ptr    = c;
                m_active = 1'b1;
                m_done   = 1'b0;
            end else begin
                m_req    = 1'b0;
                m_active = !m_bounded;
                m_done   = m_bounded;
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("req", 32'(req), 32'(m_req));
        check("done", 32'(done), 32'(m_done));
        if (m_req) begin
            check("req_ch", 32'(req_ch), 32'(m_ch));
            check("req_key", 32'(req_key), 32'(m_key));
        end
    endtask

    task automatic do_reset();
        start = 1'b0;
        ack   = 1'b0;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 1'b0;
        limit = '0;
        ch_en = '1;
        ack   = 1'b0;
        model_reset();

        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", 32'(req), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_key", 32'(req_key), 32'd0);
        check("rst_ch", 32'(req_ch), 32'd0);
        rst_n = 1'b1;
        ack   = 1'b1;
        repeat (5) cycle();
        check("idle_key", 32'(req_key), 32'd0);
        check("idle_req", 32'(req), 32'd0);

        // FREE, all channels, ack held high
        ack   = 1'b0;
        mode  = 1'b0;
        ch_en = 4'b1111;
        start = 1'b1;
        cycle();
        start = 1'b0;
        ack   = 1'b1;
        check("free_first_ch", 32'(req_ch), 32'd0);
        check("free_first_key", 32'(req_key), 32'd0);
        cycle();
        check("free_second_ch", 32'(req_ch), 32'd1);
        repeat (59) cycle();
        check("free_pre_wrap_ch", 32'(req_ch), 32'd0);
        check("free_pre_wrap_key", 32'(req_key), 32'd15);
        repeat (4) cycle();
        check("free_wrap_ch", 32'(req_ch), 32'd0);
        check("free_wrap_key", 32'(req_key), 32'd0);

        // BOUNDED limit=2, channels 0 and 2
        do_reset();
        mode  = 1'b1;
        limit = 4'd2;
        ch_en = 4'b0101;
        ack   = 1'b1;
        start = 1'b1;
        cycle();
        start = 1'b0;
        check("bnd_g0", {30'd0, req_ch}, 32'd0);
        check("bnd_k0", 32'(req_key), 32'd0);
        cycle();
        check("bnd_g1", 32'(req_ch), 32'd2);
        check("bnd_k1", 32'(req_key), 32'd0);
        cycle();
        check("bnd_g2", 32'(req_ch), 32'd0);
        check("bnd_k2", 32'(req_key), 32'd1);
        cycle();
        check("bnd_g3", 32'(req_ch), 32'd2);
        check("bnd_k3", 32'(req_key), 32'd1);
        cycle();
        check("bnd_end_req", 32'(req), 32'd0);
        check("bnd_end_done", 32'(done), 32'd1);
        repeat (3) cycle();
        check("bnd_done_hold", 32'(done), 32'd1);

        // Stall with ch_en dropping under a pending request
        do_reset();
        mode  = 1'b0;
        ch_en = 4'b1111;
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ch_en[req_ch] = 1'b0;
            cycle();
            check("stall_ch", 32'(req_ch), 32'd0);
            check("stall_key", 32'(req_key), 32'd0);
            check("stall_req", 32'(req), 32'd1);
        end
        ack = 1'b1;
        cycle();
        check("stall_next_ch", 32'(req_ch), 32'd1);
        ch_en = 4'b1111;
        repeat (3) cycle();

        // BOUNDED limit=0 goes straight to DONE
        mode  = 1'b1;
        limit = 4'd0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        check("lim0_done", 32'(done), 32'd1);
        check("lim0_req", 32'(req), 32'd0);

        // BOUNDED with nothing enabled goes straight to DONE
        limit = 4'd5;
        ch_en = 4'b0000;
        start = 1'b1;
        cycle();
        start = 1'b0;
        check("en0_done", 32'(done), 32'd1);
        check("en0_req", 32'(req), 32'd0);

        // Restart with a concurrent ack: the ack is discarded, keys restart at 0
        mode  = 1'b0;
        ch_en = 4'b1111;
        ack   = 1'b1;
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (6) cycle();
        start = 1'b1;
        cycle();
        start = 1'b0;
        check("restart_key", 32'(req_key), 32'd0);
        cycle();
        check("restart_key_next", 32'(req_key), 32'd0);
        repeat (3) cycle();

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            start = ($urandom_range(0, 19) == 0);
            mode  = 1'($urandom_range(0, 1));
            limit = KEY_W'($urandom_range(0, 5));
            ch_en = NUM_CH'($urandom);
            ack   = ($urandom_range(0, 3) != 0);
            cycle();
        end
        start = 1'b0;

        // Async reset between edges while a request is pending
        do_reset();
        mode  = 1'b0;
        ch_en = 4'b1111;
        start = 1'b1;
        cycle();
        start = 1'b0;
        ack   = 1'b1;
        repeat (5) cycle();
        ack = 1'b0;
        cycle();
        check("pre_rst_req", 32'(req), 32'd1);
        check("pre_rst_key", 32'(req_key), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_req", 32'(req), 32'd0);
        check("async_done", 32'(done), 32'd0);
        check("async_key", 32'(req_key), 32'd0);
        check("async_ch", 32'(req_ch), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) cycle();
        start = 1'b1;
        cycle();
        start = 1'b0;
        check("post_rst_ch", 32'(req_ch), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_req_gen
